// File: rtl/sha256_round_sequencer.sv
// Control sequencer for a one-round-per-cycle SHA-256 compression datapath.
// Fetches each block as 16 words, runs 64 rounds and accumulates into H, for N blocks.
module sha256_round_sequencer #(
  parameter int ADDR_W = 16,
  parameter int BLK_W  = 8
) (
  input  logic              clk,
  input  logic              rstn,
  input  logic              start,
  input  logic              abort,
  input  logic [BLK_W-1:0]  num_blocks,
  input  logic [ADDR_W-1:0] msg_base,
  output logic              busy,
  output logic              done,
  output logic              mem_rd,
  output logic [ADDR_W-1:0] mem_addr,
  output logic              w_load,
  output logic [3:0]        w_idx,
  output logic              hash_init,
  output logic              round_en,
  output logic [5:0]        round_t,
  output logic              sched_en,
  output logic              hash_accum,
  output logic [BLK_W-1:0]  blk_idx
);

  typedef enum logic [2:0] {
    IDLE  = 3'd0,
    INIT  = 3'd1,
    READ  = 3'd2,
    ROUND = 3'd3,
    ACCUM = 3'd4,
    DONE  = 3'd5
  } state_t;

  localparam int SUM_W = (ADDR_W > BLK_W + 4) ? ADDR_W : BLK_W + 4;

  state_t            state, state_nx;
  logic [5:0]        cnt, cnt_nx;
  logic [BLK_W-1:0]  blk, blk_nx;
  logic [BLK_W-1:0]  nb_q;
  logic [ADDR_W-1:0] base_q;
  logic              accept;
  logic              more_blocks;
  logic [SUM_W-1:0]  addr_sum;

  logic              busy_d, done_d, mem_rd_d, w_load_d, hash_init_d;
  logic              round_en_d, sched_en_d, hash_accum_d;
  logic [ADDR_W-1:0] mem_addr_d;
  logic [3:0]        w_idx_d;
  logic [5:0]        round_t_d;

  assign accept      = (state == IDLE) && start;
  assign more_blocks = ({1'b0, blk} + {{BLK_W{1'b0}}, 1'b1}) < {1'b0, nb_q};

  // NOTE: sequential state uses non-blocking assignments so every flop samples pre-edge values.
  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      state  <= IDLE;
      cnt    <= '0;
      blk    <= '0;
      nb_q   <= '0;
      base_q <= '0;
    end else begin
      state <= state_nx;
      cnt   <= cnt_nx;
      blk   <= blk_nx;
      if (accept) begin
        nb_q   <= num_blocks;
        base_q <= msg_base;
      end
    end
  end

  // NOTE: every always_comb output gets a default first, so no path leaves it unassigned (no latch).
  always_comb begin
    state_nx = state;
    cnt_nx   = cnt;
    blk_nx   = blk;
    unique case (state)
      IDLE: begin
        if (start) begin
          state_nx = (num_blocks == '0) ? DONE : INIT;
          cnt_nx   = '0;
          blk_nx   = '0;
        end
      end
      INIT: begin
        state_nx = READ;
        cnt_nx   = '0;
      end
      READ: begin
        if (cnt == 6'd16) begin
          state_nx = ROUND;
          cnt_nx   = '0;
        end else begin
          cnt_nx = cnt + 6'd1;
        end
      end
      ROUND: begin
        if (cnt == 6'd63) begin
          state_nx = ACCUM;
          cnt_nx   = '0;
        end else begin
          cnt_nx = cnt + 6'd1;
        end
      end
      ACCUM: begin
        cnt_nx = '0;
        if (more_blocks) begin
          state_nx = READ;
          blk_nx   = blk + {{(BLK_W-1){1'b0}}, 1'b1};
        end else begin
          state_nx = DONE;
        end
      end
      DONE: begin
        state_nx = IDLE;
        blk_nx   = '0;
      end
      default: begin
        state_nx = IDLE;
        cnt_nx   = '0;
        blk_nx   = '0;
      end
    endcase
    // Abort wins over everything except a start arriving in IDLE.
    if (abort && state != IDLE) begin
      state_nx = IDLE;
      cnt_nx   = '0;
      blk_nx   = '0;
    end
  end

  // Outputs are decoded from the next state so they can be registered without a cycle of lag.
  always_comb begin
    addr_sum     = SUM_W'(base_q) + SUM_W'({blk_nx, 4'b0000}) + SUM_W'(cnt_nx);
    busy_d       = (state_nx != IDLE);
    done_d       = (state_nx == DONE);
    hash_init_d  = (state_nx == INIT);
    mem_rd_d     = 1'b0;
    mem_addr_d   = '0;
    w_load_d     = 1'b0;
    w_idx_d      = '0;
    round_en_d   = 1'b0;
    round_t_d    = '0;
    sched_en_d   = 1'b0;
    hash_accum_d = (state_nx == ACCUM);
    if (state_nx == READ) begin
      mem_rd_d = (cnt_nx < 6'd16);
      if (mem_rd_d) mem_addr_d = ADDR_W'(addr_sum);
      w_load_d = (cnt_nx != 6'd0);
      if (w_load_d) w_idx_d = 4'(cnt_nx - 6'd1);
    end
    if (state_nx == ROUND) begin
      round_en_d = 1'b1;
      round_t_d  = cnt_nx;
      sched_en_d = (cnt_nx >= 6'd16);
    end
  end

  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      busy       <= 1'b0;
      done       <= 1'b0;
      mem_rd     <= 1'b0;
      mem_addr   <= '0;
      w_load     <= 1'b0;
      w_idx      <= '0;
      hash_init  <= 1'b0;
      round_en   <= 1'b0;
      round_t    <= '0;
      sched_en   <= 1'b0;
      hash_accum <= 1'b0;
    end else begin
      busy       <= busy_d;
      done       <= done_d;
      mem_rd     <= mem_rd_d;
      mem_addr   <= mem_addr_d;
      w_load     <= w_load_d;
      w_idx      <= w_idx_d;
      hash_init  <= hash_init_d;
      round_en   <= round_en_d;
      round_t    <= round_t_d;
      sched_en   <= sched_en_d;
      hash_accum <= hash_accum_d;
    end
  end

  assign blk_idx = blk;

endmodule

// File: tb/tb_sha256_round_sequencer.sv
// Self-checking bench: a cycle-offset reference model predicts every output
// for a run started at edge E, under random input noise while busy.
module tb_sha256_round_sequencer;

  logic        clk, rstn, start, abort;
  logic [7:0]  num_blocks;
  logic [15:0] msg_base;
  logic        busy, done, mem_rd, w_load, hash_init, round_en, sched_en, hash_accum;
  logic [15:0] mem_addr;
  logic [3:0]  w_idx;
  logic [5:0]  round_t;
  logic [7:0]  blk_idx;

  int n_checks = 0;
  int n_fail   = 0;

  typedef struct packed {
    logic        busy;
    logic        done;
    logic        mem_rd;
    logic [15:0] mem_addr;
    logic        w_load;
    logic [3:0]  w_idx;
    logic        hash_init;
    logic        round_en;
    logic [5:0]  round_t;
    logic        sched_en;
    logic        hash_accum;
    logic [7:0]  blk_idx;
  } outs_t;

  sha256_round_sequencer #(.ADDR_W(16), .BLK_W(8)) dut (
    .clk(clk), .rstn(rstn), .start(start), .abort(abort),
    .num_blocks(num_blocks), .msg_base(msg_base),
    .busy(busy), .done(done), .mem_rd(mem_rd), .mem_addr(mem_addr),
    .w_load(w_load), .w_idx(w_idx), .hash_init(hash_init),
    .round_en(round_en), .round_t(round_t), .sched_en(sched_en),
    .hash_accum(hash_accum), .blk_idx(blk_idx)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  function automatic outs_t observe();
    outs_t o;
    o = '{busy, done, mem_rd, mem_addr, w_load, w_idx, hash_init,
          round_en, round_t, sched_en, hash_accum, blk_idx};
    return o;
  endfunction

  // Expected outputs in cycle E+k for a run of n blocks; everything is idle from cycle `cut` on.
  function automatic outs_t model(int k, int n, logic [15:0] base, int cut);
    outs_t o;
    int last, r, b;
    o = '0;
    last = (n == 0) ? 1 : 2 + 82 * n;
    if (k < 1 || k > last || k >= cut) return o;
    o.busy = 1'b1;
    if (k == last) begin
      o.done    = 1'b1;
      o.blk_idx = (n > 0) ? 8'(n - 1) : 8'd0;
      return o;
    end
    if (k == 1) begin
      o.hash_init = 1'b1;
      return o;
    end
    b = (k - 2) / 82;
    r = (k - 2) % 82;
    o.blk_idx = 8'(b);
    if (r < 17) begin
      if (r < 16) begin
        o.mem_rd   = 1'b1;
        o.mem_addr = 16'(int'(base) + 16 * b + r);
      end
      if (r >= 1) begin
        o.w_load = 1'b1;
        o.w_idx  = 4'(r - 1);
      end
    end else if (r < 81) begin
      o.round_en = 1'b1;
      o.round_t  = 6'(r - 17);
      o.sched_en = (r - 17) >= 16;
    end else begin
      o.hash_accum = 1'b1;
    end
    return o;
  endfunction

  // Starts a run and compares every cycle until a few cycles past the expected done.
  task automatic run_hash(input string name, input int n, input logic [15:0] base,
                          input bit abort_at_start, input int abort_k, input int restart_k,
                          input int rst_k, output int accums, output int dones);
    int    last, cut;
    outs_t got, exp;
    last   = (n == 0) ? 1 : 2 + 82 * n;
    cut    = 1 << 30;
    if (abort_k > 0) cut = abort_k + 1;
    if (rst_k > 0)   cut = rst_k + 1;
    accums = 0;
    dones  = 0;
    @(negedge clk);
    num_blocks = n[7:0];
    msg_base   = base;
    start      = 1'b1;
    abort      = abort_at_start;
    @(posedge clk);
    for (int k = 1; k <= last + 3; k++) begin
      @(negedge clk);
      got = observe();
      exp = model(k, n, base, cut);
      n_checks++;
      if (got !== exp) begin
        n_fail++;
        $display("FAIL %s cycle E+%0d: got %h required %h", name, k, got, exp);
      end
      accums += int'(got.hash_accum);
      dones  += int'(got.done);
      start      = (k == restart_k);
      abort      = (k == abort_k);
      num_blocks = 8'($urandom);
      msg_base   = 16'($urandom);
      if (k == rst_k) begin
        #1 rstn = 1'b0;
        #1 got = observe();
        n_checks++;
        if (got !== '0) begin
          n_fail++;
          $display("FAIL %s async_reset: got %h required 0", name, got);
        end
        #1 rstn = 1'b1;
      end
    end
    start = 1'b0;
    abort = 1'b0;
  endtask

  task automatic test_reset();
    outs_t got;
    rstn = 1'b0; start = 1'b0; abort = 1'b0; num_blocks = '0; msg_base = '0;
    #12;
    got = observe();
    n_checks++;
    if (got !== '0) begin
      n_fail++;
      $display("FAIL reset_state: got %h required 0", got);
    end
    @(negedge clk);
    rstn = 1'b1;
    repeat (2) @(negedge clk);
    got = observe();
    n_checks++;
    if (got !== '0) begin
      n_fail++;
      $display("FAIL idle_after_reset: got %h required 0", got);
    end
  endtask

  task automatic test_pulse_counts(input string name, input int n, input logic [15:0] base,
                                   input bit abort_at_start, input int abort_k,
                                   input int restart_k, input int exp_accums, input int exp_dones);
    int accums, dones;
    run_hash(name, n, base, abort_at_start, abort_k, restart_k, 0, accums, dones);
    n_checks++;
    if (accums !== exp_accums || dones !== exp_dones) begin
      n_fail++;
      $display("FAIL %s pulses: got accum=%0d done=%0d required accum=%0d done=%0d",
               name, accums, dones, exp_accums, exp_dones);
    end
  endtask

  task automatic test_reset_mid_read();
    int accums, dones;
    run_hash("reset_mid_read", 1, 16'h0300, 1'b0, 0, 0, 8, accums, dones);
    n_checks++;
    if (dones !== 0) begin
      n_fail++;
      $display("FAIL reset_mid_read done: got %0d required 0", dones);
    end
    test_pulse_counts("fresh_after_reset", 1, 16'h0300, 1'b0, 0, 0, 1, 1);
  endtask

  task automatic test_random();
    int n, ak;
    logic [15:0] base;
    for (int i = 0; i < 4; i++) begin
      n    = int'($urandom_range(1, 3));
      base = 16'($urandom);
      ak   = (i % 2 == 1) ? int'($urandom_range(2, 2 + 82 * n)) : 0;
      test_pulse_counts($sformatf("random_%0d", i), n, base, 1'b0, ak, 0,
                        (ak == 0) ? n : (ak - 2) / 82 + ((ak - 2) % 82 == 81 ? 1 : 0),
                        (ak == 0 || ak == 2 + 82 * n) ? 1 : 0);
    end
  endtask

  initial begin
    test_reset();
    test_pulse_counts("single_block",    1,   16'h0100, 1'b0, 0,  0,  1,   1);
    test_pulse_counts("two_blocks",      2,   16'h0040, 1'b0, 0,  0,  2,   1);
    test_pulse_counts("zero_blocks",     0,   16'h1234, 1'b0, 0,  0,  0,   1);
    test_pulse_counts("addr_wrap",       1,   16'hFFF8, 1'b0, 0,  0,  1,   1);
    test_pulse_counts("restart_ignored", 1,   16'h0200, 1'b0, 0,  29, 1,   1);
    test_pulse_counts("abort_round30",   1,   16'h0200, 1'b0, 49, 0,  0,   0);
    test_pulse_counts("abort_in_done",   1,   16'h0500, 1'b0, 84, 0,  1,   1);
    test_pulse_counts("start_and_abort", 1,   16'h0600, 1'b1, 0,  0,  1,   1);
    test_reset_mid_read();
    test_pulse_counts("max_blocks",      255, 16'h8000, 1'b0, 0,  0,  255, 1);
    test_random();
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
